count_capture: RTL and testbench

COUNT_CAPTURE -- requirements
Module: count_capture

---
 rtl/count_capture_pkg.sv | 19 +
 rtl/sync_edge.sv | 33 +++
 rtl/count_capture.sv | 91 +++++++++
 tb/tb_count_capture.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared primitives for the count capture block: ceiling log2 and the
// occupancy-counter width derived from a FIFO depth.
package count_capture_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Occupancy has to represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int levelWidth(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a single
// history flop, producing a one-cycle pulse on each synchronized rising edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] syncChain_q, syncChain_d;
  logic                   hist_q, hist_d;

  always_comb begin
    syncChain_d = {syncChain_q[SYNC_STAGES-2:0], in};
    hist_d      = syncChain_q[SYNC_STAGES-1];
  end

  // Clearing the history flop lets a trigger held through reset still edge once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      syncChain_q <= '0;
      hist_q      <= 1'b0;
    end else begin
      syncChain_q <= syncChain_d;
      hist_q      <= hist_d;
    end
  end

  assign rise = syncChain_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/count_capture.sv
// Captures the upstream count on each synchronized trigger edge into a small
// show-ahead FIFO, with a sticky flag for captures lost to a full FIFO.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DATA_WIDTH-1:0]        count_in,
  input  logic                         trig,
  input  logic                         clr_ovf,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [levelWidth(DEPTH)-1:0] level,
  output logic                         overflow
);

  localparam int PtrW   = clog2(DEPTH);
  localparam int LevelW = levelWidth(DEPTH);
  localparam logic [LevelW-1:0] FullLevel = LevelW'(DEPTH);

  logic                  trigRise;
  logic                  pushReq, doPush, doPop, dropCapture;
  logic [PtrW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk (clk),
    .rst (rst),
    .in  (trig),
    .rise(trigRise)
  );

  // A full FIFO still accepts a capture when the head leaves on the same edge.
  always_comb begin
    pushReq     = trigRise & en;
    doPop       = out_valid & out_ready;
    doPush      = pushReq & ((level_q != FullLevel) | doPop);
    dropCapture = pushReq & ~doPush;

    wrPtr_d = doPush ? wrPtr_q + PtrW'(1) : wrPtr_q;
    rdPtr_d = doPop  ? rdPtr_q + PtrW'(1) : rdPtr_q;

    level_d = level_q;
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (dropCapture) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; its contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst && doPush) begin
      mem_q[wrPtr_q] <= count_in;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rdPtr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_capture.sv
// Drives count_capture with directed and randomized trigger traffic; a queue-based
// reference model feeds a scoreboard that checks every handshake and status output.
module tb_count_capture;

  localparam int DataWidth  = 8;
  localparam int Depth      = 4;
  localparam int SyncStages = 2;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b0;
  logic                 en       = 1'b0;
  logic [DataWidth-1:0] countIn  = '0;
  logic                 trig     = 1'b0;
  logic                 clrOvf   = 1'b0;
  logic                 outReady = 1'b0;
  logic [DataWidth-1:0] outData;
  logic                 outValid;
  logic [2:0]           level;
  logic                 overflow;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DataWidth-1:0] modelQ[$];
  logic [DataWidth-1:0] scoreQ[$];
  bit                   trigHistory [SyncStages+1];
  bit                   modelOvf = 1'b0;

  count_capture #(
    .DATA_WIDTH (DataWidth),
    .DEPTH      (Depth),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count_in (countIn),
    .trig     (trig),
    .clr_ovf  (clrOvf),
    .out_data (outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun = testsRun + 1;
    if (actual != expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic enV, input logic trigV,
                               input logic readyV, input logic clrV);
    @(posedge clk);
    #1;
    rst      = rstV;
    en       = enV;
    trig     = trigV;
    outReady = readyV;
    clrOvf   = clrV;
    countIn  = countIn + 1'b1;
  endtask

  // One trigger pulse; returns just after the edge on which its capture lands.
  task automatic pulse(input logic enV, input logic readyOnPush, output logic [DataWidth-1:0] captured);
    applyStimulus(1'b1, enV, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, enV, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, enV, 1'b0, readyOnPush, 1'b0);
    captured = countIn;
    applyStimulus(1'b1, enV, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: a capture happens SyncStages edges after trig is first seen high.
  always @(posedge clk) begin : refModel
    bit rise;
    if (!rst) begin
      modelQ.delete();
      scoreQ.delete();
      modelOvf = 1'b0;
      foreach (trigHistory[i]) trigHistory[i] = 1'b0;
    end else begin
      rise = trigHistory[SyncStages-1] && !trigHistory[SyncStages];
      if (modelQ.size() != 0 && outReady) void'(modelQ.pop_front());
      if (clrOvf) modelOvf = 1'b0;
      if (rise && en) begin
        if (modelQ.size() < Depth) begin
          modelQ.push_back(countIn);
          scoreQ.push_back(countIn);
        end else begin
          modelOvf = 1'b1;
        end
      end
      for (int i = SyncStages; i > 0; i--) trigHistory[i] = trigHistory[i-1];
      trigHistory[0] = trig;
    end
  end

  always @(negedge clk) begin : monitor
    checkOutput("level", int'(level), modelQ.size());
    checkOutput("outValid", int'(outValid), int'(modelQ.size() != 0));
    checkOutput("overflow", int'(overflow), int'(modelOvf));
    if (rst && outValid && outReady) begin
      if (scoreQ.size() == 0) checkOutput("unexpectedPop", 1, 0);
      else checkOutput("popData", int'(outData), int'(scoreQ.pop_front()));
    end
  end

  initial begin : stimulus
    logic [DataWidth-1:0] cap [5];
    logic [DataWidth-1:0] dummy;
    logic                 trigV;
    int                   trigLeft;
    bit                   fillPhase;
    int                   drainCycles;

    // Reset with trig toggling, release with trig already high at count 3.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("releaseLevel", int'(level), 0);
    checkOutput("releaseValid", int'(outValid), 0);
    checkOutput("releaseOverflow", int'(overflow), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("firstValid", int'(outValid), 1);
    checkOutput("firstData", int'(outData), 5);
    checkOutput("firstLevel", int'(level), 1);

    // Fill to capacity and drop the fifth capture.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      pulse(1'b1, 1'b0, cap[p]);
      @(negedge clk);
      if (p == 3) checkOutput("fullLevel", int'(level), 4);
    end
    checkOutput("dropOverflow", int'(overflow), 1);
    checkOutput("dropHead", int'(outData), int'(cap[0]));

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clearOverflow", int'(overflow), 0);

    // Push and pop on the same edge while full.
    pulse(1'b1, 1'b1, dummy);
    @(negedge clk);
    checkOutput("fullPushPopLevel", int'(level), 4);
    checkOutput("fullPushPopOverflow", int'(overflow), 0);
    checkOutput("fullPushPopHead", int'(outData), int'(cap[1]));

    // Trigger while disabled.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, dummy);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("disabledLevel", int'(level), 0);

    // Reset while a trigger edge is in flight.
    pulse(1'b1, 1'b0, dummy);
    pulse(1'b1, 1'b0, dummy);
    @(negedge clk);
    checkOutput("preResetLevel", int'(level), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("inFlightDiscarded", int'(level), 0);

    // Randomized traffic alternating fill-heavy and drain-heavy phases.
    trigV    = 1'b0;
    trigLeft = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (trigLeft == 0) begin
        trigV    = ~trigV;
        trigLeft = $urandom_range(1, 4);
      end
      trigLeft  = trigLeft - 1;
      fillPhase = ((cyc / 250) % 2) == 0;
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0, trigV,
                    fillPhase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 39) == 0);
    end

    drainCycles = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    while (modelQ.size() != 0 && drainCycles < 40) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      drainCycles = drainCycles + 1;
    end
    @(negedge clk);
    checkOutput("drainTimeout", modelQ.size(), 0);
    checkOutput("scoreboardEmpty", scoreQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
